// File: rtl/tpclk_gen.sv
// Timing-pulse generator: prescaled unit strobe, RUN/STEP machine-cycle FSM and a 5-tap unit-delay line.
// Define TPCLK_STEP_EN to build the single-step path (STEP state, step_req edge detector, step_ack).
module tpclk_gen #(
  parameter int TICK        = 2,
  parameter int SHORT_UNITS = 6,
  parameter int LONG_UNITS  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step_req,
  input  logic       long_cycle,
  output logic       tpclk,
  output logic [4:0] tap,
  output logic       tpwp,
  output logic       cyc_done,
  output logic       step_ack
);

  localparam logic [7:0] TICK_LAST = 8'(TICK - 1);
  localparam logic [3:0] SHORT_LEN = 4'(SHORT_UNITS);
  localparam logic [3:0] LONG_LEN  = 4'(LONG_UNITS);

`ifdef TPCLK_STEP_EN
  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t     state_reg, state_next;
  logic [7:0] p_reg, p_next;
  logic [3:0] u_reg, u_next;
  logic [3:0] len_reg, len_next;
  logic       tpclk_reg, tpclk_next;
  logic       tpwp_reg, tpwp_next;
  logic       done_reg, done_next;
  logic       ack_reg, ack_next;
  logic [4:0] tap_reg;
  logic       strobe;
  logic       last_unit;
  logic       start;
  logic       active_next;
  logic       step_pending;

`ifdef TPCLK_STEP_EN
  logic step_prev_reg;
  logic step_pending_reg, step_pending_next;
  logic step_edge;

  // Edges are only remembered while idle; anything seen during a cycle is dropped.
  always_comb begin
    step_edge         = step_req & ~step_prev_reg;
    step_pending      = step_pending_reg | step_edge;
    step_pending_next = 1'b0;
    if (state_reg == IDLE && !strobe) begin
      step_pending_next = step_pending;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_prev_reg    <= 1'b0;
      step_pending_reg <= 1'b0;
    end else begin
      step_prev_reg    <= step_req;
      step_pending_reg <= step_pending_next;
    end
  end
`else
  logic unused_step;
  assign unused_step  = step_req;
  assign step_pending = 1'b0;
`endif

  always_comb begin
    strobe     = (p_reg == TICK_LAST);
    p_next     = strobe ? 8'd0 : p_reg + 8'd1;
    last_unit  = (u_reg == len_reg - 4'd1);
    state_next = state_reg;
    u_next     = u_reg;
    len_next   = len_reg;
    start      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (strobe) begin
          if (run) begin
            state_next = RUN;
            start      = 1'b1;
          end else if (step_pending) begin
`ifdef TPCLK_STEP_EN
            state_next = STEP;
            start      = 1'b1;
`endif
          end
        end
      end
      RUN: begin
        if (strobe) begin
          if (!last_unit) begin
            u_next = u_reg + 4'd1;
          end else if (run) begin
            start = 1'b1;
          end else begin
            state_next = IDLE;
            u_next     = 4'd0;
          end
        end
      end
`ifdef TPCLK_STEP_EN
      STEP: begin
        if (strobe) begin
          if (!last_unit) begin
            u_next = u_reg + 4'd1;
          end else begin
            state_next = IDLE;
            u_next     = 4'd0;
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
        u_next     = 4'd0;
      end
    endcase

    // long_cycle is captured only at the strobe that launches a cycle.
    if (start) begin
      u_next   = 4'd0;
      len_next = long_cycle ? LONG_LEN : SHORT_LEN;
    end

    active_next = (state_next != IDLE);
    tpclk_next  = active_next && (u_next < (len_next >> 1));
    tpwp_next   = active_next && (u_next == len_next - 4'd2);
    done_next   = active_next && (u_next == len_next - 4'd1) && (p_next == TICK_LAST);
`ifdef TPCLK_STEP_EN
    ack_next    = done_next && (state_next == STEP);
`else
    ack_next    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      p_reg     <= 8'd0;
      u_reg     <= 4'd0;
      len_reg   <= SHORT_LEN;
      tpclk_reg <= 1'b0;
      tpwp_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      u_reg     <= u_next;
      len_reg   <= len_next;
      tpclk_reg <= tpclk_next;
      tpwp_reg  <= tpwp_next;
      done_reg  <= done_next;
      ack_reg   <= ack_next;
    end
  end

  // Delay line: each stage moves one unit per strobe and keeps shifting while idle.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_tap
      logic tap_in;
      if (gi == 0) begin : g_first
        assign tap_in = tpclk_reg;
      end else begin : g_rest
        assign tap_in = tap_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          tap_reg[gi] <= 1'b0;
        end else if (strobe) begin
          tap_reg[gi] <= tap_in;
        end
      end
    end
  endgenerate

  assign tpclk    = tpclk_reg;
  assign tap      = tap_reg;
  assign tpwp     = tpwp_reg;
  assign cyc_done = done_reg;
  assign step_ack = ack_reg;

endmodule
